// File: rtl/mips_dmem_responder.sv
// Memory-side responder for the MIPS load/store bus: one word request at a time,
// programmable wait states, one-cycle acknowledge with read data and error flag.
module mips_dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: the initiator raises req and holds it and the request fields
    // until ack; a request is taken only when req is high in IDLE, and ack is a
    // single-cycle pulse that also qualifies rdata and err.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t state, next_state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [0:(2**ADDR_W)-1];

    logic              accept;
    logic              enter_resp;
    logic              t_we;
    logic [31:0]       t_addr;
    logic [31:0]       t_wdata;
    logic [3:0]        t_be;
    logic              t_err;
    logic [ADDR_W-1:0] t_idx;
    logic              q_err;

    assign accept     = (state == S_IDLE) && req;
    assign enter_resp = (next_state == S_RESP) && (state != S_RESP);

    // With no wait states RESP is entered on the accept edge itself, before the
    // request is latched, so the live inputs stand in for the latched copies.
    always_comb begin
        t_we    = we_q;
        t_addr  = addr_q;
        t_wdata = wdata_q;
        t_be    = be_q;
        if (state == S_IDLE) begin
            t_we    = we;
            t_addr  = addr;
            t_wdata = wdata;
            t_be    = byte_en;
        end
    end

    assign t_err = (t_addr[1:0] != 2'b00) || (t_addr[31:ADDR_W+2] != '0);
    assign t_idx = t_addr[ADDR_W+1:2];
    assign q_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == LAST_CNT) next_state = S_RESP;
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ack  = 1'b0;
        busy = 1'b0;
        case (state)
            S_WAIT: busy = 1'b1;
            S_RESP: begin
                ack  = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign err       = ack && q_err;
    assign rdata     = rdata_q;
    assign dbg_state = state;

    // Request latch and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (accept) begin
            cnt     <= 4'd0;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= byte_en;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Read data is captured on the edge entering RESP and cleared as ack falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (enter_resp) begin
            rdata_q <= (!t_we && !t_err) ? mem[t_idx] : 32'd0;
        end else if (state == S_RESP) begin
            rdata_q <= 32'd0;
        end
    end

    // Storage is not reset; a store is suppressed if reset is active at its edge.
    always_ff @(posedge clk) begin
        if (enter_resp && !reset && t_we && !t_err) begin
            for (int i = 0; i < 4; i++) begin
                if (t_be[i]) mem[t_idx][8*i +: 8] <= t_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: one instance with two wait states and
// one with none, checked against hand-computed latencies and memory contents.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  byte_en;
    logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  dbg_a, dbg_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .ack(ack_a), .rdata(rdata_a),
        .err(err_a), .busy(busy_a), .dbg_state(dbg_a)
    );

    mips_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .ack(ack_b), .rdata(rdata_b),
        .err(err_b), .busy(busy_b), .dbg_state(dbg_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance sel (0 = two wait states, 1 = none).
    task automatic txn(input int sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic e, output int lat);
        logic got_ack;
        got_ack = 1'b0;
        rd  = 32'd0;
        e   = 1'b0;
        lat = 0;
        @(negedge clk);
        we = w; addr = a; wdata = d; byte_en = be;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (i == 0) begin
                we = ~w; addr = 32'hFFFF_FFFC; wdata = ~d; byte_en = ~be;
            end
            if ((sel == 0) ? ack_a : ack_b) begin
                got_ack = 1'b1;
                rd = (sel == 0) ? rdata_a : rdata_b;
                e  = (sel == 0) ? err_a : err_b;
                check("busy_at_ack", {31'd0, (sel == 0) ? busy_a : busy_b}, 32'd1);
                break;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        if (!got_ack) begin
            check("ack_timeout", 32'd0, 32'd1);
            lat = 99;
        end
        @(posedge clk); #1;
        check("ack_falls", {31'd0, (sel == 0) ? ack_a : ack_b}, 32'd0);
        check("rdata_clears", (sel == 0) ? rdata_a : rdata_b, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic        saw;

        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        we = 1'b0; addr = 32'd0; wdata = 32'd0; byte_en = 4'd0;

        // Reset held four cycles, then ten idle cycles
        repeat (4) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_b_outs", {ack_b, busy_b, err_b, |rdata_b}, 32'd0);
        @(negedge clk); reset = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack_a || busy_a || err_a || rdata_a != 0 || ack_b || busy_b) saw = 1'b1;
        end
        check("idle_quiet", {31'd0, saw}, 32'd0);

        // Full-word store and load
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, e, lat);
        check("st_lat", lat, 32'd3);
        check("st_err", {31'd0, e}, 32'd0);
        check("st_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, rd, e, lat);
        check("ld_lat", lat, 32'd3);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_err", {31'd0, e}, 32'd0);

        // Byte-lane store, then an empty-mask store
        txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e, lat);
        txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, rd, e, lat);
        check("byte_merge", rd, 32'hDEADBEAA);
        txn(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, rd, e, lat);
        txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, rd, e, lat);
        check("be_none", rd, 32'hDEADBEAA);

        // Misaligned and out-of-range accesses
        txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'b1111, rd, e, lat);
        txn(0, 1'b0, 32'h13, 32'd0, 4'b0000, rd, e, lat);
        check("mis_err", {31'd0, e}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h400, 32'd0, 4'b0000, rd, e, lat);
        check("oor_err", {31'd0, e}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'b1111, rd, e, lat);
        check("oor_st_err", {31'd0, e}, 32'd1);
        txn(0, 1'b0, 32'h0, 32'd0, 4'b0000, rd, e, lat);
        check("word0_kept", rd, 32'h0BADF00D);
        check("word0_err", {31'd0, e}, 32'd0);

        // req dropped after one cycle: transaction still completes
        @(negedge clk);
        we = 1'b0; addr = 32'h10; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        lat = 1;
        while (!ack_a && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("drop_lat", lat, 32'd3);
        check("drop_rdata", rdata_a, 32'hDEADBEAA);
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy_a) saw = 1'b1;
        end
        check("drop_no_reaccept", {31'd0, saw}, 32'd0);

        // Reset during the wait states of a store aborts it
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, rd, e, lat);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h55667788; byte_en = 4'b1111; req_a = 1'b1;
        @(posedge clk); #1;
        check("abort_in_wait", {31'd0, busy_a}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        req_a = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack_a) saw = 1'b1;
        end
        check("abort_no_ack", {31'd0, saw}, 32'd0);
        @(negedge clk); reset = 1'b0;
        txn(0, 1'b0, 32'h20, 32'd0, 4'b0000, rd, e, lat);
        check("abort_mem_kept", rd, 32'h11223344);

        // Zero wait states: back-to-back loads with req held high
        txn(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'b1111, rd, e, lat);
        check("b_st_lat", lat, 32'd1);
        @(negedge clk);
        we = 1'b0; addr = 32'h8; req_b = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 7) req_b = 1'b0;
            check($sformatf("b2b_ack_%0d", k), {31'd0, ack_b}, {31'd0, k[0]});
            check($sformatf("b2b_busy_%0d", k), {31'd0, busy_b}, {31'd0, k[0]});
            if (ack_b) begin
                lat++;
                check($sformatf("b2b_rdata_%0d", k), rdata_b, 32'hCAFEF00D);
            end
        end
        check("b2b_count", lat, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
